scene_background_anim: RTL and testbench
========================================

// Module: scene_background_anim
// PURPOSE
//  Parametrised successor of the static menu background stage in the VGA chain.
//  Paints sky, two grass bands, the road, a scrolling dashed yellow midline and an optional blinking menu panel.
//  Sits directly after the timing generator; timing signals pass through with 1-cycle latency.
//  Scroll offset and blink state advance once per frame, on the vblank rising edge.
// PARAMETERS
//  H_ACTIVE     1024    visible columns; hcount_in >= H_ACTIVE paints black
//  SKY_END      629     last sky row (sky = rows 0..SKY_END)
//  GRASS1_END   646     last row of upper grass band
//  ROAD_END     714     last road row
//  GRASS2_END   762     last row of lower grass band; rows above it down to the road end are grass, rows below are black
//  LINE_Y       679     first row of midline
//  LINE_H       4       midline height in rows
//  DASH_LEN     32      dash length in px; must be < DASH_PERIOD
//  DASH_PERIOD  64      dash+gap in px; power of two, >= 16
//  MENU_X/MENU_Y 411/84 top-left corner of menu panel
//  MENU_W/MENU_H 200/288 menu panel size
//  BORDER       4       highlight border width in px
//  BLINK_FRAMES 30      frames per blink half-period (>=1)
//  SKY/GRASS/ROAD/LINE/MENU/BORDER_COLOR  12'h5cf/494/9ab/ff4/f52/fff
// PORTS
//  clk          in   1   pixel clock
//  rst_n        in   1   synchronous reset, active low
//  hcount_in    in   11  column
//  vcount_in    in   11  row
//  hsync_in     in   1   horizontal sync
//  vsync_in     in   1   vertical sync
//  hblnk_in     in   1   horizontal blank
//  vblnk_in     in   1   vertical blank
//  menu_en      in   1   1 = draw menu panel; 0 = sky in its place
//  scroll_en    in   1   1 = midline scrolls
//  scroll_speed in   4   px per frame added to scroll offset
//  hcount_out/vcount_out/hsync_out/vsync_out/hblnk_out/vblnk_out  out  as inputs, delayed 1 clk
//  rgb_out      out  12  pixel colour, 4:4:4
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all outputs 0; offset=0, blink_cnt=0, blink_ph=0, vblnk_prev=1.
//  - frame_tick = vblnk_in & ~vblnk_prev; vblnk_prev <= vblnk_in each clk.
//    Because vblnk_prev resets to 1, releasing reset inside vblank gives no spurious tick.
//  - Scroll: on frame_tick with scroll_en=1: offset <= (offset+scroll_speed) mod DASH_PERIOD (wraps, never saturates).
//    Sampled only at frame_tick, so mid-frame speed changes take effect in the next frame.
//  - Blink: on frame_tick: if blink_cnt==BLINK_FRAMES-1 then blink_cnt<=0 and blink_ph toggles; else blink_cnt++.
//    The blink counters run regardless of menu_en.
//  - Dash: dash_on = (((hcount_in+offset) & (DASH_PERIOD-1)) < DASH_LEN).
//    Use an 11-bit sum, truncated; with offset increasing, the pattern moves left.
//  - rgb priority, highest first, all evaluated on the *_in values:
//    1. hblnk_in|vblnk_in -> 0.
//    2. hcount_in >= H_ACTIVE -> 0.
//    3. menu_en and inside panel (MENU_X<=h<MENU_X+MENU_W, MENU_Y<=v<MENU_Y+MENU_H):
//       BORDER_COLOR if blink_ph and within BORDER px of any panel edge; else MENU_COLOR.
//    4. LINE_Y<=v<LINE_Y+LINE_H and dash_on -> LINE_COLOR.
//    5. v<=SKY_END -> SKY; v<=GRASS1_END -> GRASS; v<=ROAD_END -> ROAD; v<=GRASS2_END -> GRASS; else 0.
//  - Latency: exactly 1 clk from inputs to every output; no combinational in->out paths.
//  - offset/blink updated at frame_tick are visible from the next cycle; vblank is black, so no tear.
// TESTING
//  1. Reset held low for 3 clk with vblnk_in=1 -> all outputs 0; release -> no tick; offset stays 0 until next vblank rise.
//  2. h=0, v=0, no blank -> rgb_out=12'h5cf one clk later.
//     h=500, v=700 -> 12'h9ab. h=500, v=640 -> 12'h494. h=500, v=765 -> 12'h000.
//  3. scroll_en=1, speed=5: after 13 ticks offset=65 mod 64=1.
//     Pixel h=31, v=680 -> ROAD (pos 32); h=30 -> LINE 12'hff4.
//  4. menu_en=1, h=411, v=84: with blink_ph=0 -> 12'hf52; after 30 ticks -> 12'hfff.
//     h=500, v=200 stays 12'hf52. With menu_en=0 -> 12'h5cf.
//  5. hblnk_in=1 over panel -> rgb_out=0.
//     hsync/vsync/hblnk/vblnk and counters equal the inputs delayed 1 clk for a random sequence.
//  6. rst_n pulsed low mid-frame with offset!=0 -> offset=0, blink_ph=0, outputs 0 the next clk.

Source files
------------

// File: rtl/scene_background_anim.sv
// Scene background painter for the VGA chain.
// Draws sky, two grass bands, the road, a scrolling dashed midline and an
// optional blinking menu panel. All timing signals pass through with one
// clock of latency. Scroll offset and blink phase advance on each vblank rise.
module scene_background_anim #(
  parameter int          H_ACTIVE     = 1024,
  parameter int          SKY_END      = 629,
  parameter int          GRASS1_END   = 646,
  parameter int          ROAD_END     = 714,
  parameter int          GRASS2_END   = 762,
  parameter int          LINE_Y       = 679,
  parameter int          LINE_H       = 4,
  parameter int          DASH_LEN     = 32,
  parameter int          DASH_PERIOD  = 64,
  parameter int          MENU_X       = 411,
  parameter int          MENU_Y       = 84,
  parameter int          MENU_W       = 200,
  parameter int          MENU_H       = 288,
  parameter int          BORDER       = 4,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] SKY_COLOR    = 12'h5cf,
  parameter logic [11:0] GRASS_COLOR  = 12'h494,
  parameter logic [11:0] ROAD_COLOR   = 12'h9ab,
  parameter logic [11:0] LINE_COLOR   = 12'hff4,
  parameter logic [11:0] MENU_COLOR   = 12'hf52,
  parameter logic [11:0] BORDER_COLOR = 12'hfff
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic        menu_en,
  input  logic        scroll_en,
  input  logic [3:0]  scroll_speed,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // DASH_PERIOD is a power of two >= 16, so OFF_W >= 4 and the offset wraps naturally.
  localparam int OFF_W = $clog2(DASH_PERIOD);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Region bounds widened to 12 bits so panel end coordinates cannot overflow.
  localparam logic [11:0] H_ACT_L  = 12'(H_ACTIVE);
  localparam logic [11:0] SKY_L    = 12'(SKY_END);
  localparam logic [11:0] GRASS1_L = 12'(GRASS1_END);
  localparam logic [11:0] ROAD_L   = 12'(ROAD_END);
  localparam logic [11:0] GRASS2_L = 12'(GRASS2_END);
  localparam logic [11:0] LINE_LO  = 12'(LINE_Y);
  localparam logic [11:0] LINE_HI  = 12'(LINE_Y + LINE_H);
  localparam logic [11:0] MX_LO    = 12'(MENU_X);
  localparam logic [11:0] MX_HI    = 12'(MENU_X + MENU_W);
  localparam logic [11:0] MY_LO    = 12'(MENU_Y);
  localparam logic [11:0] MY_HI    = 12'(MENU_Y + MENU_H);
  localparam logic [11:0] BX_LO    = 12'(MENU_X + BORDER);
  localparam logic [11:0] BX_HI    = 12'(MENU_X + MENU_W - BORDER);
  localparam logic [11:0] BY_LO    = 12'(MENU_Y + BORDER);
  localparam logic [11:0] BY_HI    = 12'(MENU_Y + MENU_H - BORDER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [OFF_W-1:0] offset_q, offset_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_ph_q, blink_ph_d;
  logic             vblnk_prev_q;
  logic             frame_tick;
  logic [11:0]      rgb_d;

  logic [11:0] h_w, v_w;
  logic [10:0] dash_sum;
  logic        dash_on, in_panel, on_border, in_line;

  assign frame_tick = vblnk_in & ~vblnk_prev_q;
  assign h_w        = {1'b0, hcount_in};
  assign v_w        = {1'b0, vcount_in};

  // Dash pattern: 11-bit wrap is harmless because 2048 is a multiple of the period.
  assign dash_sum = hcount_in + 11'(offset_q);
  assign dash_on  = (dash_sum & 11'(DASH_PERIOD - 1)) < 11'(DASH_LEN);

  assign in_line   = (v_w >= LINE_LO) && (v_w < LINE_HI);
  assign in_panel  = (h_w >= MX_LO) && (h_w < MX_HI) && (v_w >= MY_LO) && (v_w < MY_HI);
  assign on_border = (h_w < BX_LO) || (h_w >= BX_HI) || (v_w < BY_LO) || (v_w >= BY_HI);

  // Per-frame animation state: scroll offset and blink counter/phase.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    offset_d    = offset_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (frame_tick) begin
      if (scroll_en) offset_d = offset_q + OFF_W'(scroll_speed);
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
  end

  // Pixel colour selection in priority order.
  always_comb begin
    rgb_d = 12'h000;
    if (hblnk_in || vblnk_in) begin
      rgb_d = 12'h000;
    end else if (h_w >= H_ACT_L) begin
      rgb_d = 12'h000;
    end else if (menu_en && in_panel) begin
      rgb_d = (blink_ph_q && on_border) ? BORDER_COLOR : MENU_COLOR;
    end else if (in_line && dash_on) begin
      rgb_d = LINE_COLOR;
    end else if (v_w <= SKY_L) begin
      rgb_d = SKY_COLOR;
    end else if (v_w <= GRASS1_L) begin
      rgb_d = GRASS_COLOR;
    end else if (v_w <= ROAD_L) begin
      rgb_d = ROAD_COLOR;
    end else if (v_w <= GRASS2_L) begin
      rgb_d = GRASS_COLOR;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      offset_q     <= '0;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      vblnk_prev_q <= 1'b1;
      hcount_out   <= '0;
      vcount_out   <= '0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      hblnk_out    <= 1'b0;
      vblnk_out    <= 1'b0;
      rgb_out      <= '0;
    end else begin
      offset_q     <= offset_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      vblnk_prev_q <= vblnk_in;
      hcount_out   <= hcount_in;
      vcount_out   <= vcount_in;
      hsync_out    <= hsync_in;
      vsync_out    <= vsync_in;
      hblnk_out    <= hblnk_in;
      vblnk_out    <= vblnk_in;
      rgb_out      <= rgb_d;
    end
  end

endmodule

// File: tb/tb_scene_background_anim.sv
// Self-checking bench for scene_background_anim: directed scenarios plus a
// randomized run, all compared against a frame-level behavioural model.
module tb_scene_background_anim;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        menu_en, scroll_en;
  logic [3:0]  scroll_speed;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: scroll offset in pixels, number of frame ticks since reset,
  // and the previously seen vblank level.
  int m_offset = 0;
  int m_ticks  = 0;
  bit m_prev   = 1'b1;

  scene_background_anim dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .menu_en(menu_en), .scroll_en(scroll_en), .scroll_speed(scroll_speed),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected pixel colour from the scene description, using plain integers.
  function automatic logic [11:0] model_rgb(int h, int v, bit hb, bit vb, bit menu,
                                            int off, bit ph);
    if (hb || vb) return 12'h000;
    if (h >= 1024) return 12'h000;
    if (menu && h >= 411 && h < 611 && v >= 84 && v < 372) begin
      if (ph && (h < 415 || h >= 607 || v < 88 || v >= 368)) return 12'hfff;
      return 12'hf52;
    end
    if (v >= 679 && v < 683 && ((h + off) % 64) < 32) return 12'hff4;
    if (v <= 629) return 12'h5cf;
    if (v <= 646) return 12'h494;
    if (v <= 714) return 12'h9ab;
    if (v <= 762) return 12'h494;
    return 12'h000;
  endfunction

  // One clock: predict, advance the DUT, check every output, update the model.
  task automatic cycle();
    logic [11:0] e_rgb;
    logic [29:0] e_pass;
    bit          tick;
    bit          ph;
    ph = ((m_ticks / 30) % 2) == 1;
    if (!rst_n) begin
      e_rgb  = 12'h000;
      e_pass = '0;
    end else begin
      e_rgb  = model_rgb(int'(hcount_in), int'(vcount_in), hblnk_in, vblnk_in,
                         menu_en, m_offset, ph);
      e_pass = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
    end
    tick = rst_n && vblnk_in && !m_prev;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_offset = 0;
      m_ticks  = 0;
      m_prev   = 1'b1;
    end else begin
      if (tick) begin
        if (scroll_en) m_offset = (m_offset + int'(scroll_speed)) % 64;
        m_ticks++;
      end
      m_prev = vblnk_in;
    end
    check("rgb", {20'd0, rgb_out}, {20'd0, e_rgb});
    check("pass", {2'd0, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out},
          {2'd0, e_pass});
  endtask

  // Visible pixel for one clock, then the explicit expected colour.
  task automatic pixel(input int h, input int v, input logic [11:0] exp, input string tag);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = 1'b0;
    vblnk_in  = 1'b0;
    cycle();
    check(tag, {20'd0, rgb_out}, {20'd0, exp});
  endtask

  // One frame boundary: vblank low for a clock, then high (rising edge).
  task automatic frame_tick();
    vblnk_in = 1'b0;
    cycle();
    vblnk_in = 1'b1;
    cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0;
    hblnk_in = 1'b0; vblnk_in = 1'b1;
    menu_en = 1'b0; scroll_en = 1'b0; scroll_speed = 4'd0;

    // Reset held in vblank, then released inside vblank: no tick.
    for (int i = 0; i < 3; i++) cycle();
    check("reset_rgb", {20'd0, rgb_out}, 32'd0);
    rst_n = 1'b1;
    scroll_en = 1'b1; scroll_speed = 4'd7;
    cycle();
    cycle();
    check("no_spurious_tick", 32'(m_ticks), 32'd0);
    scroll_en = 1'b0; scroll_speed = 4'd0;

    // Static scene colours (offset 0: h=31 is dashed, h=32 is gap).
    pixel(0, 0, 12'h5cf, "sky_origin");
    pixel(500, 700, 12'h9ab, "road");
    pixel(500, 640, 12'h494, "grass1");
    pixel(500, 740, 12'h494, "grass2");
    pixel(500, 765, 12'h000, "below_grass2");
    pixel(1024, 100, 12'h000, "h_active_edge");
    pixel(1023, 100, 12'h5cf, "last_column");
    pixel(31, 680, 12'hff4, "dash_off0");
    pixel(32, 680, 12'h9ab, "gap_off0");

    // Scrolling: 13 ticks at speed 5 -> offset 1.
    scroll_en = 1'b1; scroll_speed = 4'd5;
    for (int i = 0; i < 13; i++) frame_tick();
    check("offset_wrap", 32'(m_offset), 32'd1);
    pixel(31, 680, 12'h9ab, "scroll_gap");
    pixel(30, 680, 12'hff4, "scroll_dash");
    pixel(30, 678, 12'h9ab, "above_line");
    pixel(30, 683, 12'h9ab, "below_line");
    scroll_en = 1'b0;

    // Menu panel and blink (13 ticks elapsed, phase still 0).
    menu_en = 1'b1;
    pixel(411, 84, 12'hf52, "menu_corner_ph0");
    for (int i = 0; i < 17; i++) frame_tick();
    pixel(411, 84, 12'hfff, "menu_corner_ph1");
    pixel(610, 371, 12'hfff, "menu_far_corner");
    pixel(500, 200, 12'hf52, "menu_inner");
    pixel(611, 200, 12'h5cf, "menu_right_out");
    hcount_in = 11'd411; vcount_in = 11'd84; hblnk_in = 1'b1; vblnk_in = 1'b0;
    cycle();
    check("hblank_over_panel", {20'd0, rgb_out}, 32'd0);
    menu_en = 1'b0;
    pixel(411, 84, 12'h5cf, "menu_off");

    // Randomized run against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        hcount_in = 11'($urandom_range(400, 620));
        vcount_in = 11'($urandom_range(80, 380));
      end else begin
        hcount_in = 11'($urandom_range(0, 1100));
        vcount_in = 11'($urandom_range(0, 800));
      end
      if ($urandom_range(0, 3) == 0) vcount_in = 11'($urandom_range(676, 686));
      hsync_in     = 1'($urandom);
      vsync_in     = 1'($urandom);
      hblnk_in     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) vblnk_in = ~vblnk_in;
      menu_en      = 1'($urandom);
      scroll_en    = 1'($urandom);
      scroll_speed = 4'($urandom);
      cycle();
    end

    // Mid-frame reset with a non-zero offset.
    vblnk_in = 1'b0; hblnk_in = 1'b0; menu_en = 1'b0;
    scroll_en = 1'b1; scroll_speed = 4'd5;
    for (int i = 0; i < 20 && m_offset == 0; i++) frame_tick();
    check("offset_nonzero", 32'(m_offset != 0), 32'd1);
    hcount_in = 11'd500; vcount_in = 11'd300; vblnk_in = 1'b0;
    rst_n = 1'b0;
    cycle();
    check("midreset_rgb", {20'd0, rgb_out}, 32'd0);
    rst_n = 1'b1;
    scroll_en = 1'b0;
    pixel(31, 680, 12'hff4, "post_reset_dash");
    pixel(32, 680, 12'h9ab, "post_reset_gap");
    menu_en = 1'b1;
    pixel(411, 84, 12'hf52, "post_reset_ph0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
